sram_arbiter: RTL
=================

# sram_arbiter

Shares the single 16-bit DE2-115 SRAM port between the audio recorder (write requester) and the audio player (read requester) inside `Top`. It runs in the 12 MHz audio clock domain. It owns every SRAM control pin and the DQ tristate. It serialises accesses with a req/ack handshake and round-robin arbitration, so neither path can starve.

## Interface
- `ACCESS_CYC`, default 2: cycles the SRAM strobe (WE_N or OE_N) is held low per access; legal range 1..15.
- `i_clk` in 1: 12 MHz audio clock; the only clock.
- `i_rst` in 1: reset, synchronous, active-high.
- `i_wr_req` in 1: recorder write request; held high until `o_wr_ack`.
- `i_wr_addr` in 20: write word address; stable while `i_wr_req` is high.
- `i_wr_data` in 16: write data; stable while `i_wr_req` is high.
- `o_wr_ack` out 1: one-cycle pulse marking the final write cycle.
- `i_rd_req` in 1: player read request; held high until `o_rd_ack`.
- `i_rd_addr` in 20: read word address; stable while `i_rd_req` is high.
- `o_rd_ack` out 1: one-cycle pulse marking the final read cycle.
- `o_rd_valid` out 1: one-cycle pulse, the cycle after `o_rd_ack`.
- `o_rd_data` out 16: read data; valid when `o_rd_valid` is high, held until the next read completes.
- `o_busy` out 1: high in any non-IDLE state.
- `o_SRAM_ADDR` out 20: SRAM address.
- `io_SRAM_DQ` inout 16: SRAM data bus.
- `o_SRAM_WE_N`, `o_SRAM_OE_N`, `o_SRAM_CE_N`, `o_SRAM_LB_N`, `o_SRAM_UB_N` out 1 each: SRAM control pins, all active-low.

## Operation
- States: IDLE, WR, RD.
- IDLE:
  - Neither request high: stay in IDLE.
  - Exactly one request high: grant that requester.
  - Both high: grant the requester not granted last. `last_grant` resets to RD, so the first tie goes to WR.
  - On grant: latch address (and write data for WR) into registers, load the cycle counter with 0, update `last_grant`.
- WR:
  - `o_SRAM_ADDR` = latched address; DQ driven with latched data.
  - CE_N, LB_N, UB_N, WE_N = 0; OE_N = 1.
  - Counter increments each cycle.
  - When counter = ACCESS_CYC-1: assert `o_wr_ack` and return to IDLE at the next edge.
- RD:
  - DQ high-Z; CE_N, LB_N, UB_N, OE_N = 0; WE_N = 1.
  - When counter = ACCESS_CYC-1: assert `o_rd_ack`, capture DQ into `o_rd_data` at that edge, pulse `o_rd_valid` in the following cycle, return to IDLE.
- IDLE outputs: all SRAM control pins 1, DQ high-Z, `o_SRAM_ADDR` holds its last value.
- Acks are Moore outputs of the final access cycle. Requesters deassert or re-present `req` at that same edge, so IDLE never re-grants a stale request.
- Address and data inputs are sampled only at grant. Changes while the request is pending-but-ungranted are taken at grant; changes after grant are ignored.
- Every transaction passes through IDLE, so there is always at least one cycle with DQ high-Z between a write and a read (bus turnaround).

## Timing
- Reset values: all SRAM `_N` pins 1; DQ high-Z; `o_SRAM_ADDR` = 0; `o_wr_ack`, `o_rd_ack`, `o_rd_valid`, `o_busy` = 0; `o_rd_data` = 0; state IDLE; `last_grant` = RD.
- Request seen high in IDLE in cycle k:
  - Access occupies cycles k+1 .. k+ACCESS_CYC.
  - Ack is high in cycle k+ACCESS_CYC.
  - `o_rd_valid` is high in cycle k+ACCESS_CYC+1.
- Throughput: one access per ACCESS_CYC+1 cycles. With ACCESS_CYC=2 at 12 MHz that is 4 Maccess/s, well above 2×48 kS/s.
- Under continuous contention, grants alternate WR, RD, WR, ... Worst-case wait for a request is one full foreign access plus one IDLE cycle.
- Reset asserted mid-access: the next edge forces IDLE and reset values. No ack or valid is emitted, and the aborted write is not counted as complete.
- Counter width is 4 bits. It is compared to ACCESS_CYC-1; no wrap occurs within the legal range.

## Structure
- Package `sram_arb_pkg`:
  - `typedef enum logic [1:0] {S_IDLE, S_WR, S_RD} sram_arb_state_t`
  - `localparam SRAM_AW = 20`, `SRAM_DW = 16`
  - `typedef enum logic {GNT_WR, GNT_RD} sram_gnt_t`
- Single module, no sub-module. The tristate is `assign io_SRAM_DQ = (state == S_WR) ? wdata_q : 'z;`.
- Instantiated inside `Top` in place of the recorder's and player's direct SRAM drive.

## Test plan
- Reset, then idle 10 cycles -> all `_N` pins 1, DQ high-Z, `o_busy` = 0, no acks.
- Write addr 0x00010 data 0xBEEF, ACCESS_CYC=2 -> WE_N low exactly in cycles k+1..k+2, `o_wr_ack` in k+2; then read 0x00010 -> `o_rd_valid` with `o_rd_data` = 0xBEEF in k'+3.
- Both requests high at the same edge after reset, each re-requesting immediately after its ack, 8 transactions -> grant order WR, RD, WR, RD...; never two consecutive grants to one side while the other is pending.
- Write then read back-to-back -> at least one cycle with DQ high-Z and WE_N = OE_N = 1 between WE_N rising and OE_N falling.
- `i_rst` asserted in the second cycle of a write -> next cycle IDLE, WE_N = 1, no `o_wr_ack`; after release, a fresh read grants normally.
- ACCESS_CYC=1 build: a sequence of 100 random reads and writes against an SRAM model -> every read returns the last written value; ack-to-request spacing is exactly 2 cycles under continuous load.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// Shared types for the SRAM port arbiter: FSM states, grant owner and bus widths.
package sram_arb_pkg;

    localparam int SRAM_AW = 20;
    localparam int SRAM_DW = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WR,
        S_RD
    } sram_arb_state_t;

    typedef enum logic {
        GNT_WR,
        GNT_RD
    } sram_gnt_t;

    // Round-robin pick: a lone request wins outright; on a tie the side that
    // was not granted last goes next, so neither requester can starve.
    function automatic sram_gnt_t pick_grant(input logic      wr_req,
                                             input logic      rd_req,
                                             input sram_gnt_t last_grant);
        sram_gnt_t gnt;
        if (wr_req && rd_req) begin
            gnt = (last_grant == GNT_WR) ? GNT_RD : GNT_WR;
        end else if (wr_req) begin
            gnt = GNT_WR;
        end else begin
            gnt = GNT_RD;
        end
        return gnt;
    endfunction

endpackage

// File: rtl/sram_arbiter.sv
// Arbiter sharing the single 16-bit SRAM port between the audio recorder
// (writes) and the audio player (reads). Each access is granted from IDLE,
// holds its strobe low for ACCESS_CYC cycles and returns to IDLE, which also
// guarantees a high-Z turnaround cycle between a write and a following read.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    // Strobe-low cycles per access; legal range 1..15 (4-bit counter).
    parameter int unsigned ACCESS_CYC = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,

    input  logic               i_wr_req,
    input  logic [SRAM_AW-1:0] i_wr_addr,
    input  logic [SRAM_DW-1:0] i_wr_data,
    output logic               o_wr_ack,

    input  logic               i_rd_req,
    input  logic [SRAM_AW-1:0] i_rd_addr,
    output logic               o_rd_ack,
    output logic               o_rd_valid,
    output logic [SRAM_DW-1:0] o_rd_data,

    output logic               o_busy,

    output logic [SRAM_AW-1:0] o_SRAM_ADDR,
    inout  wire  [SRAM_DW-1:0] io_SRAM_DQ,
    output logic               o_SRAM_WE_N,
    output logic               o_SRAM_OE_N,
    output logic               o_SRAM_CE_N,
    output logic               o_SRAM_LB_N,
    output logic               o_SRAM_UB_N
);

    localparam logic [3:0] CNT_LAST = 4'(ACCESS_CYC - 1);

    sram_arb_state_t    state_q,      state_d;
    sram_gnt_t          last_grant_q, last_grant_d;
    logic [3:0]         cnt_q,        cnt_d;
    logic [SRAM_AW-1:0] addr_q,       addr_d;
    logic [SRAM_DW-1:0] wdata_q,      wdata_d;
    logic [SRAM_DW-1:0] rd_data_q,    rd_data_d;
    logic               rd_valid_q,   rd_valid_d;

    sram_gnt_t          gnt;
    logic               last_cyc;

    assign last_cyc = (cnt_q == CNT_LAST);

    // Next-state logic: grant from IDLE, count strobe cycles, finish the access.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rd_data_d    = rd_data_q;
        rd_valid_d   = 1'b0;
        gnt          = pick_grant(i_wr_req, i_rd_req, last_grant_q);

        case (state_q)
            S_IDLE: begin
                if (i_wr_req || i_rd_req) begin
                    cnt_d        = '0;
                    last_grant_d = gnt;
                    if (gnt == GNT_WR) begin
                        state_d = S_WR;
                        addr_d  = i_wr_addr;
                        wdata_d = i_wr_data;
                    end else begin
                        state_d = S_RD;
                        addr_d  = i_rd_addr;
                    end
                end
            end

            S_WR: begin
                if (last_cyc) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            S_RD: begin
                if (last_cyc) begin
                    state_d    = S_IDLE;
                    rd_data_d  = io_SRAM_DQ;
                    rd_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        // NOTE: registers are updated with non-blocking assignments so every
        // flop samples the pre-edge values, independent of statement order.
        if (i_rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= GNT_RD;
            cnt_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
        end
    end

    // Acks mark the final access cycle; an access aborted by reset in that
    // same cycle never completes, so the ack is masked while reset is high.
    assign o_wr_ack   = (state_q == S_WR) && last_cyc && !i_rst;
    assign o_rd_ack   = (state_q == S_RD) && last_cyc && !i_rst;
    assign o_rd_valid = rd_valid_q;
    assign o_rd_data  = rd_data_q;
    assign o_busy     = (state_q != S_IDLE);

    // SRAM pins decode straight from the state; the address register holds
    // its last value through IDLE.
    assign o_SRAM_ADDR = addr_q;
    assign o_SRAM_CE_N = (state_q == S_IDLE);
    assign o_SRAM_LB_N = (state_q == S_IDLE);
    assign o_SRAM_UB_N = (state_q == S_IDLE);
    assign o_SRAM_WE_N = (state_q != S_WR);
    assign o_SRAM_OE_N = (state_q != S_RD);

    // DQ is driven only while writing; IDLE and RD leave the bus released.
    assign io_SRAM_DQ = (state_q == S_WR) ? wdata_q : 'z;

endmodule
